// File: rtl/scan_chain_sequencer.sv
// scan_chain_sequencer: run/step control and byte-wise scan-chain load/readback for a host
module scan_chain_sequencer #(
  parameter int CHAIN_LEN   = 40,
  parameter int STEP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic       din_valid,
  output logic       din_ready,
  input  logic [7:0] din_data,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic [7:0] dout_data,
  output logic       processor_enable,
  output logic       scan_enable,
  output logic       scan_in,
  input  logic       scan_out,
  output logic       busy
);
  localparam int RW = $clog2(CHAIN_LEN + 1);
  localparam int SW = $clog2(STEP_CYCLES + 1);
  typedef enum logic [2:0] {IDLE_HALT, IDLE_RUN, STEP, LOAD, SHIFT, EMIT} state_t;
  state_t r_state, w_next;
  logic [SW-1:0] r_step;
  logic [RW-1:0] r_rem;
  logic [2:0] r_j;
  logic [7:0] r_sh, r_cap;
  logic w_idle, w_cmd, w_last;
  assign w_idle = r_state == IDLE_HALT || r_state == IDLE_RUN;
  assign w_cmd = w_idle && cmd_valid;
  // a byte ends after 8 bits or when the chain runs out, whichever is first
  assign w_last = r_j == 3'd7 || r_rem == RW'(1);
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE_HALT, IDLE_RUN:
        if (cmd_valid) w_next = cmd_op == 2'b00 ? IDLE_RUN : cmd_op == 2'b01 ? IDLE_HALT : cmd_op == 2'b10 ? LOAD : STEP;
      STEP:    if (r_step == SW'(1)) w_next = IDLE_HALT;
      LOAD:    if (din_valid) w_next = SHIFT;
      SHIFT:   if (w_last) w_next = EMIT;
      EMIT:    if (dout_ready) w_next = r_rem != '0 ? LOAD : IDLE_HALT;
      default: w_next = IDLE_HALT;
    endcase
  end
  always_ff @(posedge clk)
    if (!rst) r_state <= IDLE_HALT;
    else r_state <= w_next;
  always_ff @(posedge clk)
    if (!rst) begin
      r_step <= '0;
      r_rem  <= '0;
      r_j    <= '0;
      r_sh   <= '0;
      r_cap  <= '0;
    end else begin
      if (w_cmd && cmd_op == 2'b11) r_step <= SW'(STEP_CYCLES);
      if (w_cmd && cmd_op == 2'b10) r_rem <= RW'(CHAIN_LEN);
      if (r_state == STEP) r_step <= r_step - SW'(1);
      if (r_state == LOAD && din_valid) begin
        r_sh <= din_data;
        r_j  <= '0;
      end
      if (r_state == SHIFT) begin
        r_sh       <= r_sh >> 1;
        r_cap[r_j] <= scan_out;
        r_j        <= r_j + 3'd1;
        r_rem      <= r_rem - RW'(1);
      end
      if (r_state == EMIT && dout_ready) r_cap <= '0;
    end
  assign cmd_ready        = w_idle;
  assign busy             = !w_idle;
  assign din_ready        = r_state == LOAD;
  assign dout_valid       = r_state == EMIT;
  assign dout_data        = r_cap;
  assign processor_enable = r_state == IDLE_RUN || r_state == STEP;
  assign scan_enable      = r_state == SHIFT;
  assign scan_in          = r_state == SHIFT && r_sh[0];
endmodule

// File: tb/tb_scan_chain_sequencer.sv
// tb_scan_chain_sequencer: random and directed checks of run/step/shift against a chain-level model
module tb_scan_chain_sequencer;
  localparam int CL = 12;
  localparam int SC = 2;
  localparam int NB = (CL + 7) / 8;
  logic clk = 0, rst = 0;
  logic cmd_valid = 0, cmd_ready;
  logic [1:0] cmd_op = 0;
  logic din_valid = 0, din_ready;
  logic [7:0] din_data = 0;
  logic dout_valid, dout_ready = 0;
  logic [7:0] dout_data;
  logic processor_enable, scan_enable, scan_in, scan_out, busy;
  logic [CL-1:0] chain = '0, pre_val = '0;
  logic pre_en = 0;
  int n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  scan_chain_sequencer #(.CHAIN_LEN(CL), .STEP_CYCLES(SC)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
    .processor_enable(processor_enable), .scan_enable(scan_enable), .scan_in(scan_in),
    .scan_out(scan_out), .busy(busy)
  );
  // chain: bit 0 is the tail (scan_out), new bits enter at the head
  assign scan_out = chain[0];
  always @(posedge clk)
    if (pre_en) chain <= pre_val;
    else if (scan_enable) chain <= {scan_in, chain[CL-1:1]};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic preload(input logic [CL-1:0] v);
    pre_val = v;
    pre_en = 1;
    tick();
    pre_en = 0;
  endtask
  task automatic cmd(input logic [1:0] op);
    cmd_valid = 1;
    cmd_op = op;
    tick();
    cmd_valid = 0;
  endtask
  task automatic do_shift(input logic [CL-1:0] pre, input logic [7:0] b0, input logic [7:0] b1, input int bp, input bit rnd);
    logic [7:0] bytes [2];
    logic [31:0] newc, exp_b;
    logic [7:0] mask, held;
    int rem, cyc, k, n, h;
    bytes[0] = b0;
    bytes[1] = b1;
    newc = 0;
    rem = CL;
    cyc = 0;
    preload(pre);
    cmd(2'b10);
    chk("load_pe", 32'(processor_enable), 0);
    chk("load_busy", 32'(busy), 1);
    for (int b = 0; b < NB; b++) begin
      k = rem < 8 ? rem : 8;
      mask = 8'((1 << k) - 1);
      n = 0;
      while (!din_ready && n < 40) begin tick(); n++; cyc++; end
      chk("din_ready", 32'(din_ready), 1);
      if (rnd) repeat ($urandom_range(0, 2)) begin
        dout_ready = 1'($urandom);
        tick();
        cyc++;
      end
      dout_ready = 0;
      din_valid = 1;
      din_data = bytes[b];
      tick();
      cyc++;
      din_valid = 0;
      n = 0;
      while (scan_enable && n < 20) begin
        chk("se_pe_excl", 32'(processor_enable), 0);
        tick();
        n++;
        cyc++;
      end
      chk("shift_len", n, k);
      chk("dout_valid", 32'(dout_valid), 1);
      exp_b = (32'(pre) >> (8 * b)) & 32'(mask);
      chk("dout_data", 32'(dout_data), exp_b);
      h = bp < 0 ? int'($urandom_range(0, 3)) : bp;
      held = dout_data;
      repeat (h) begin
        tick();
        cyc++;
        chk("bp_hold", {21'd0, dout_valid, scan_enable, din_ready, dout_data}, {21'd0, 1'b1, 1'b0, 1'b0, held});
      end
      newc |= (32'(bytes[b]) & 32'(mask)) << (8 * b);
      dout_ready = 1;
      tick();
      cyc++;
      dout_ready = 0;
      rem -= k;
    end
    chk("end_idle", {28'd0, busy, cmd_ready, processor_enable, scan_enable}, 32'b0100);
    if (!rnd && bp == 0) chk("shift_cycles", cyc, NB * 2 + CL);
    chk("chain", 32'(chain), 32'(newc[CL-1:0]));
  endtask
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    tick();
    tick();
    chk("rst_out", {25'd0, processor_enable, scan_enable, scan_in, cmd_ready, din_ready, dout_valid, busy}, 32'b0001000);
    chk("rst_dout", 32'(dout_data), 0);
    rst = 1;
    tick();
    cmd(2'b00);
    chk("run_pe", 32'(processor_enable), 1);
    chk("run_busy", 32'(busy), 0);
    tick();
    tick();
    chk("run_hold", 32'(processor_enable), 1);
    cmd(2'b01);
    chk("halt_pe", 32'(processor_enable), 0);
    cmd(2'b11);
    chk("step1", {29'd0, processor_enable, cmd_ready, busy}, 32'b101);
    cmd_valid = 1;
    cmd_op = 2'b00;
    tick();
    cmd_valid = 0;
    chk("step2", {29'd0, processor_enable, cmd_ready, busy}, 32'b101);
    tick();
    chk("step_end", {29'd0, processor_enable, cmd_ready, busy}, 32'b010);
    cmd(2'b00);
    cmd(2'b11);
    tick();
    tick();
    chk("step_from_run", {29'd0, processor_enable, cmd_ready, busy}, 32'b010);
    do_shift(12'hABC, 8'hA5, 8'h0F, 0, 0);
    do_shift(12'($urandom), 8'($urandom), 8'($urandom), 5, 0);
    cmd(2'b00);
    do_shift(12'($urandom), 8'($urandom), 8'($urandom), 0, 0);
    preload(12'h5A3);
    cmd(2'b10);
    din_valid = 1;
    din_data = 8'hFF;
    tick();
    din_valid = 0;
    tick();
    tick();
    chk("mid_se", 32'(scan_enable), 1);
    rst = 0;
    tick();
    rst = 1;
    chk("mid_rst", {27'd0, scan_enable, busy, cmd_ready, din_ready, dout_valid}, 32'b00100);
    do_shift(12'($urandom), 8'($urandom), 8'($urandom), -1, 0);
    repeat (8) begin
      if ($urandom_range(0, 1) == 1) cmd(2'b00);
      do_shift(12'($urandom), 8'($urandom), 8'($urandom), -1, 1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
